// File: rtl/superscalar_issue_queue_pkg.sv
// rtl/superscalar_issue_queue_pkg.sv - shared opcode constants, field positions and decode flag type
package superscalar_issue_queue_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int REG_W   = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef struct packed {
        logic writes_rd;
        logic reads_rs1;
        logic reads_rs2;
        logic is_mem;
        logic is_ctrl;
    } dep_flags_t;

endpackage

// File: rtl/superscalar_issue_queue_issue_dep_check.sv
// rtl/superscalar_issue_queue_issue_dep_check.sv - per-instruction register/memory/control usage decode
module issue_dep_check
    import superscalar_issue_queue_pkg::*;
(
    input  logic [24:0]      instr,
    output dep_flags_t       flags,
    output logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2
);

    logic [6:0] opcode;

    assign opcode = instr[6:0];
    assign rd     = instr[RD_LSB  +: REG_W];
    assign rs1    = instr[RS1_LSB +: REG_W];
    assign rs2    = instr[RS2_LSB +: REG_W];

    // Unknown opcodes fall through with every flag clear.
    always_comb begin
        flags           = '0;
        flags.writes_rd = opcode inside {OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC};
        flags.reads_rs1 = opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
        flags.reads_rs2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};
        flags.is_mem    = opcode inside {OP_LOAD, OP_STORE};
        flags.is_ctrl   = opcode inside {OP_BRANCH, OP_JAL, OP_JALR};
    end

endmodule

// File: rtl/superscalar_issue_queue.sv
// rtl/superscalar_issue_queue.sv - in-order fetch buffer issuing up to LANES hazard-free instructions per cycle
module superscalar_issue_queue
    import superscalar_issue_queue_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    input  logic [$clog2(LANES+1)-1:0] fetch_count,
    input  logic [LANES*XLEN-1:0]      fetch_instr,
    input  logic [LANES*XLEN-1:0]      fetch_pc,
    output logic                       fetch_ready,
    output logic [LANES-1:0]           issue_valid,
    output logic [LANES*XLEN-1:0]      issue_instr,
    output logic [LANES*XLEN-1:0]      issue_pc,
    input  logic                       issue_stall,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int FW = $clog2(LANES+1);

    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   deq_n;
    logic            enq;
    logic            deq;
    logic            grp_ok;

    dep_flags_t       flags [LANES];
    logic [REG_W-1:0] rd_f  [LANES];
    logic [REG_W-1:0] rs1_f [LANES];
    logic [REG_W-1:0] rs2_f [LANES];

    // Ready reserves a whole group of slots so a same-cycle dequeue never has to be trusted.
    assign fetch_ready = (count <= CW'(DEPTH - LANES));
    assign occupancy   = count;
    assign enq         = fetch_valid & fetch_ready & ~flush;
    assign deq         = ~issue_stall & ~flush;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PW-1:0] idx;
        assign idx = head + PW'(k);
        assign issue_instr[k*XLEN +: XLEN] = mem_instr[idx];
        assign issue_pc[k*XLEN +: XLEN]    = mem_pc[idx];

        issue_dep_check u_dep (
            .instr (mem_instr[idx][24:0]),
            .flags (flags[k]),
            .rd    (rd_f[k]),
            .rs1   (rs1_f[k]),
            .rs2   (rs2_f[k])
        );
    end

    // Lane k joins the group only if every earlier lane joined and none of them conflicts with it.
    always_comb begin
        issue_valid    = '0;
        grp_ok         = 1'b0;
        issue_valid[0] = (count != '0);
        for (int k = 1; k < LANES; k++) begin
            grp_ok = issue_valid[k-1] && (count > CW'(k));
            for (int j = 0; j < k; j++) begin
                if (flags[j].is_ctrl)
                    grp_ok = 1'b0;
                if (flags[j].is_mem && flags[k].is_mem)
                    grp_ok = 1'b0;
                if (flags[j].writes_rd && (rd_f[j] != '0) &&
                    ((flags[k].reads_rs1 && (rs1_f[k] == rd_f[j])) ||
                     (flags[k].reads_rs2 && (rs2_f[k] == rd_f[j])) ||
                     (flags[k].writes_rd && (rd_f[k]  == rd_f[j]))))
                    grp_ok = 1'b0;
            end
            issue_valid[k] = grp_ok;
        end
    end

    always_comb begin
        deq_n = '0;
        for (int k = 0; k < LANES; k++)
            deq_n = deq_n + CW'(issue_valid[k]);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (enq && (FW'(k) < fetch_count)) begin
                mem_instr[tail + PW'(k)] <= fetch_instr[k*XLEN +: XLEN];
                mem_pc[tail + PW'(k)]    <= fetch_pc[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= tail + PW'(fetch_count);
            if (deq)
                head <= head + PW'(deq_n);
            count <= count + (enq ? CW'(fetch_count) : '0) - (deq ? deq_n : '0);
        end
    end

endmodule

// File: tb/tb_superscalar_issue_queue.sv
// tb/tb_superscalar_issue_queue.sv - directed and randomized checks against a queue-based reference model
module tb_superscalar_issue_queue;

    localparam int L = 2;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [1:0]  fetch_count;
    logic [63:0] fetch_instr;
    logic [63:0] fetch_pc;
    logic        fetch_ready;
    logic [1:0]  issue_valid;
    logic [63:0] issue_instr;
    logic [63:0] issue_pc;
    logic        issue_stall;
    logic        flush;
    logic [3:0]  occupancy;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_instr [$];
    logic [31:0] q_pc    [$];

    superscalar_issue_queue #(.LANES(L), .DEPTH(D), .XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_count (fetch_count),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_pc    (issue_pc),
        .issue_stall (issue_stall),
        .flush       (flush),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit op_wr(input logic [6:0] op);
        return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h67 ||
               op == 7'h6f || op == 7'h37 || op == 7'h17;
    endfunction
    function automatic bit op_r1(input logic [6:0] op);
        return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 ||
               op == 7'h63 || op == 7'h67;
    endfunction
    function automatic bit op_r2(input logic [6:0] op);
        return op == 7'h33 || op == 7'h23 || op == 7'h63;
    endfunction
    function automatic bit op_mem(input logic [6:0] op);
        return op == 7'h03 || op == 7'h23;
    endfunction
    function automatic bit op_ctl(input logic [6:0] op);
        return op == 7'h63 || op == 7'h6f || op == 7'h67;
    endfunction

    // Number of head instructions the issue rules allow out together.
    function automatic int exp_n();
        int n;
        if (q_instr.size() == 0) return 0;
        n = 1;
        for (int k = 1; k < L; k++) begin
            logic [31:0] ik, ij;
            bit blk;
            if (k >= q_instr.size()) break;
            ik  = q_instr[k];
            blk = 1'b0;
            for (int j = 0; j < k; j++) begin
                ij = q_instr[j];
                if (op_ctl(ij[6:0])) blk = 1'b1;
                if (op_mem(ij[6:0]) && op_mem(ik[6:0])) blk = 1'b1;
                if (op_wr(ij[6:0]) && ij[11:7] != 5'd0 &&
                    ((op_r1(ik[6:0]) && ik[19:15] == ij[11:7]) ||
                     (op_r2(ik[6:0]) && ik[24:20] == ij[11:7]) ||
                     (op_wr(ik[6:0]) && ik[11:7]  == ij[11:7])))
                    blk = 1'b1;
            end
            if (blk) break;
            n++;
        end
        return n;
    endfunction

    task automatic cycle(input bit fv, input int fc, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] p0, input logic [31:0] p1, input bit stall, input bit fl);
        int n;
        bit rdy;
        fetch_valid = fv;
        fetch_count = 2'(fc);
        fetch_instr = {i1, i0};
        fetch_pc    = {p1, p0};
        issue_stall = stall;
        flush       = fl;
        @(negedge clk);
        n   = exp_n();
        rdy = (D - q_instr.size()) >= L;
        chk("issue_valid", 64'(issue_valid), 64'((1 << n) - 1));
        chk("occupancy", 64'(occupancy), 64'(q_instr.size()));
        chk("fetch_ready", 64'(fetch_ready), 64'(rdy));
        for (int k = 0; k < n; k++) begin
            chk("issue_pc", 64'(issue_pc[k*32 +: 32]), 64'(q_pc[k]));
            chk("issue_instr", 64'(issue_instr[k*32 +: 32]), 64'(q_instr[k]));
        end
        if (fl) begin
            q_instr.delete();
            q_pc.delete();
        end else begin
            if (!stall)
                for (int k = 0; k < n; k++) begin
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                end
            if (fv && rdy) begin
                if (fc > 0) begin q_instr.push_back(i0); q_pc.push_back(p0); end
                if (fc > 1) begin q_instr.push_back(i1); q_pc.push_back(p1); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++)
            cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] mk_addi(input int pc);
        logic [4:0] rd;
        rd = 5'(((pc >> 2) % 31) + 1);
        return {12'd1, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic fill(input int pc, input int cnt, input bit stall);
        cycle(1, cnt, mk_addi(pc), mk_addi(pc + 4), 32'(pc), 32'(pc + 4), stall, 0);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f};
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
    endfunction

    initial begin
        reset       = 1'b0;
        fetch_valid = 1'b0;
        fetch_count = '0;
        fetch_instr = '0;
        fetch_pc    = '0;
        issue_stall = 1'b0;
        flush       = 1'b0;
        #12;
        chk("rst_valid", 64'(issue_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        cycle(1, 2, 32'h00500093, 32'h00700113, 32'h0, 32'h4, 0, 0);
        chk("fill_iv", 64'(issue_valid), 64'h3);
        chk("fill_pc", issue_pc, {32'h4, 32'h0});
        idle(1);
        chk("fill_occ", 64'(occupancy), 64'd0);

        cycle(1, 2, 32'h00500093, 32'h002081B3, 32'h10, 32'h14, 0, 0);
        chk("raw_iv0", 64'(issue_valid), 64'h1);
        idle(1);
        chk("raw_iv1", 64'(issue_valid), 64'h1);
        idle(2);

        cycle(1, 2, 32'h00500093, 32'h00700093, 32'h20, 32'h24, 0, 0);
        chk("waw_iv", 64'(issue_valid), 64'h1);
        idle(3);
        cycle(1, 2, 32'h00002283, 32'h00602223, 32'h30, 32'h34, 0, 0);
        chk("mem_iv", 64'(issue_valid), 64'h1);
        idle(3);
        cycle(1, 2, 32'h00000463, 32'h00100393, 32'h40, 32'h44, 0, 0);
        chk("ctl_iv", 64'(issue_valid), 64'h1);
        idle(3);
        cycle(1, 2, 32'h00100013, 32'h000001B3, 32'h50, 32'h54, 0, 0);
        chk("x0_iv", 64'(issue_valid), 64'h3);
        idle(2);

        for (int g = 0; g < 4; g++)
            fill(8 * g, 2, 1);
        chk("full_occ", 64'(occupancy), 64'd8);
        chk("full_ready", 64'(fetch_ready), 64'd0);
        fill(32'h100, 2, 1);
        chk("full_refuse", 64'(occupancy), 64'd8);
        for (int g = 0; g < 4; g++) begin
            chk("wrap_pc", 64'(issue_pc[31:0]), 64'(8 * g));
            idle(1);
        end
        chk("wrap_empty", 64'(occupancy), 64'd0);

        for (int g = 0; g < 3; g++)
            fill(32'h40 + 8 * g, 2, 1);
        cycle(1, 2, mk_addi(32'h80), mk_addi(32'h84), 32'h80, 32'h84, 0, 1);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_iv", 64'(issue_valid), 64'd0);

        for (int g = 0; g < 3; g++)
            fill(32'h60 + 8 * g, 2, 1);
        fill(32'h78, 1, 1);
        chk("occ7", 64'(occupancy), 64'd7);
        chk("occ7_ready", 64'(fetch_ready), 64'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("occ5", 64'(occupancy), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_iv", 64'(issue_valid), 64'd0);
        chk("async_occ", 64'(occupancy), 64'd0);
        q_instr.delete();
        q_pc.delete();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int c = 0; c < 400; c++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2), rnd_instr(), rnd_instr(),
                  $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/superscalar_issue_queue.md
Name: superscalar_issue_queue

Overview:
- Parametrised in-order fetch/issue buffer between instruction memory and LANES decode/execute lanes of the superscalar core.
- Generalises the single-instruction-per-cycle core front end: buffers DEPTH instructions with their PCs and issues up to LANES per cycle.
- Performs intra-group RAW/WAW checks, limits each group to one memory operation, and ends a group at any control transfer.
- Supports flush on branch redirect.

Parameters:
- LANES, 2, issue/fetch width in instructions (1..4).
- DEPTH, 8, queue entries; power of two, and DEPTH >= 2*LANES.
- XLEN, 32, instruction and PC width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_valid  input  1  fetch group present.
- fetch_count  input  $clog2(LANES+1)  number of valid instructions in the group, lanes 0..count-1.
- fetch_instr  input  LANES*XLEN  lane k in bits [k*XLEN +: XLEN].
- fetch_pc  input  LANES*XLEN  PC per lane.
- fetch_ready  output  1  free entries >= LANES.
- issue_valid  output  LANES  per-lane issue qualifier; always thermometer (lane k valid implies lanes 0..k-1 valid).
- issue_instr  output  LANES*XLEN  instructions at head..head+LANES-1.
- issue_pc  output  LANES*XLEN  matching PCs.
- issue_stall  input  1  downstream cannot accept; nothing dequeues.
- flush  input  1  redirect; discard all entries.
- occupancy  output  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Storage and pointers
  - Circular storage with head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a separate count register.
- Reset (reset low, asynchronous)
  - head = tail = count = 0.
  - issue_valid = 0, occupancy = 0, fetch_ready = 1.
  - Storage contents are don't-care.
- Enqueue
  - Occurs when fetch_valid & fetch_ready & !flush.
  - Writes fetch_count entries at tail..tail+fetch_count-1 (mod DEPTH); tail += fetch_count.
  - fetch_count = 0 with fetch_valid is a no-op.
- fetch_ready
  - Equals (DEPTH - count) >= LANES, from registered count only.
  - Ignores the same-cycle dequeue; conservative, no combinational path from issue_stall.
- Latency
  - An instruction enqueued at edge N can appear on issue outputs in the cycle after edge N.
  - issue_instr/issue_pc are combinational reads from the head entries.
- Group formation (combinational, from head; lane k = entry head+k)
  - Lane 0 valid iff count >= 1.
  - Lane k>0 valid iff lane k-1 valid, count > k, and none of the following hold:
    - (a) Any earlier lane j<k writes rd != 0 and lane k reads that register as rs1 or rs2 (RAW), or writes the same rd (WAW).
    - (b) Lane k is a load (0000011) or store (0100011) and an earlier lane is also a load or store.
    - (c) An earlier lane is a branch (1100011), jal (1101111) or jalr (1100111).
  - Register writers: opcodes 0110011, 0010011, 0000011, 1100111, 1101111, 0110111, 0010111.
  - rs1 readers: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - rs2 readers: 0110011, 0100011, 1100011.
  - Unknown opcodes read nothing and write nothing.
- Dequeue
  - If !issue_stall & !flush: head += popcount(issue_valid) and count updates.
  - issue_valid is still driven while issue_stall is high; downstream ignores it.
- Simultaneous enqueue and dequeue
  - count_next = count + enq - deq.
  - Never overflows, because fetch_ready reserves LANES slots.
- Flush
  - Highest priority: head = tail = count = 0 at the next edge.
  - Same-cycle enqueue and dequeue are discarded.
- Empty queue: issue_valid = 0; the outputs carry stale data.
- Full queue: fetch_ready = 0 and enqueue is refused; the source must hold its group.
- Reset mid-operation: immediate return to the reset state, regardless of clk.

Decomposition:
- Shared package (core-wide):
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - Field slice positions: rd [11:7], rs1 [19:15], rs2 [24:20].
- One sub-module: issue_dep_check.
  - Purely combinational per-instruction decode of the flags writes_rd, reads_rs1, reads_rs2, is_mem, is_ctrl.
  - Instantiated LANES times; the pairwise comparisons stay in the top.

Test Plan:
- Reset/fill:
  - Release reset, enqueue 0x00500093 (addi x1,x0,5) and 0x00700113 (addi x2,x0,7), count 2, PCs 0x0/0x4.
  - Expect next cycle: issue_valid = 2'b11, issue_pc = {0x4,0x0}, occupancy 2 → 0 after the edge.
- RAW split:
  - Enqueue addi x1,x0,5 then add x3,x1,x2 (0x002081B3).
  - Expect issue_valid = 2'b01, then 2'b01 for add on the following cycle.
  - WAW check: addi x1 / addi x1 behaves the same.
- Memory/control:
  - lw x5,0(x0) then sw x6,4(x0): expect single issue per cycle.
  - beq x0,x0,8 then addi x7,x0,1: expect issue_valid = 2'b01.
  - rd = x0 writer followed by a reader of x0: dual issue.
- Full/wrap:
  - Hold issue_stall = 1 and enqueue 4 groups of 2 (DEPTH 8).
  - Expect fetch_ready = 0 at occupancy 7 and 8 (fetch_ready already drops at occupancy 7), occupancy = 8.
  - Release the stall and drain, checking PC order 0x0..0x1C across pointer wrap.
- Flush:
  - With occupancy 6, assert flush together with fetch_valid.
  - Expect occupancy 0 and issue_valid = 0 next cycle, with the fetched group dropped.
- Async reset:
  - Drop reset between clock edges with occupancy 5.
  - Expect issue_valid = 0 and occupancy = 0 immediately, before the next clk edge.
